ureg_shift_ctrl: RTL and testbench

//  Command sequencer that sits directly upstream of the universal shift register chain (two cascaded
//  4-bit stages forming an 8-bit register). Accepts one command per valid/ready handshake and drives
//  the register mode selects (S1,S0), parallel data D and serial inputs SDL/SDR cycle by cycle.

---
 rtl/ureg_shift_ctrl_if.sv | 30 +++
 rtl/ureg_shift_ctrl.sv | 95 +++++++++
 tb/tb_ureg_shift_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ureg_shift_ctrl_if.sv
// ureg_shift_ctrl_if: command handshake plus register-drive signals between sequencer and its environment.
interface ureg_shift_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_amt;
    logic             cmd_fill;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] D;
    logic             S1;
    logic             S0;
    logic             SDR;
    logic             SDL;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_amt, cmd_fill, q_in,
        input  cmd_ready, D, S1, S0, SDR, SDL, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_amt, cmd_fill, q_in,
        output cmd_ready, D, S1, S0, SDR, SDL, busy, done
    );
endinterface

// File: rtl/ureg_shift_ctrl.sv
// ureg_shift_ctrl: sequences LOAD/SHR/SHL/ROR commands onto a universal shift register's S1,S0,D,SDL,SDR.
// Define UREG_ROTATE_EN to make op 11 a true rotate right (SDR fed from q_in[0]); otherwise it behaves as SHR.
module ureg_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic              clk,
    input logic              CLR,
    ureg_shift_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
    typedef enum logic [1:0] {OP_LOAD, OP_SHR, OP_SHL, OP_ROR} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             accept;
    logic             right_bit;

    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        d_d     = d_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d   = op_e'(bus.cmd_op);
                fill_d = bus.cmd_fill;
                cnt_d  = bus.cmd_amt;
                if (op_e'(bus.cmd_op) == OP_LOAD) begin
                    state_d = LOAD;
                    s_d     = 2'b11;
                    d_d     = bus.cmd_data;
                end else if (bus.cmd_amt != '0) begin
                    state_d = SHIFT;
                    s_d     = (op_e'(bus.cmd_op) == OP_SHL) ? 2'b10 : 2'b01;
                end else begin
                    state_d = DONE;
                end
            end
            LOAD: begin
                state_d = DONE;
                s_d     = 2'b00;
                d_d     = '0;
            end
            SHIFT: begin
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
                s_d     = (cnt_q == CNT_W'(1)) ? 2'b00 : s_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
            s_q     <= 2'b00;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            d_q     <= d_d;
        end
    end

`ifdef UREG_ROTATE_EN
    // Rotation feeds back the register's current LSB, so this path is combinational from q_in.
    assign right_bit = (op_q == OP_ROR) ? bus.q_in[0] : fill_q;
`else
    assign right_bit = fill_q;
`endif

    assign bus.cmd_ready = (state_q == IDLE) && !CLR;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.S1        = s_q[1];
    assign bus.S0        = s_q[0];
    assign bus.D         = d_q;
    assign bus.SDL       = (state_q == SHIFT) && (op_q == OP_SHL) && fill_q;
    assign bus.SDR       = (state_q == SHIFT) && (op_q != OP_SHL) && right_bit;
endmodule

// File: tb/tb_ureg_shift_ctrl.sv
// tb_ureg_shift_ctrl: directed checks of the sequencer driving a modelled 8-bit universal shift register.
module tb_ureg_shift_ctrl;
`ifdef UREG_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] q   = 8'h00;
    int         passed = 0;
    int         total  = 0;

    ureg_shift_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus ();

    ureg_shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .CLR (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.q_in = q;

    always @(posedge clk)
        case ({bus.S1, bus.S0})
            2'b01:   q <= {bus.SDR, q[7:1]};
            2'b10:   q <= {q[6:0], bus.SDL};
            2'b11:   q <= bus.D;
            default: q <= q;
        endcase

    task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [3:0] amt, input logic fill);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_amt   = amt;
        bus.cmd_fill  = fill;
        #1;
        total++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL accept_ready got %b want 1", bus.cmd_ready);
        else passed++;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b10;
        bus.cmd_data  = 8'hEE;
        bus.cmd_amt   = 4'hF;
        bus.cmd_fill  = ~fill;
    endtask

    task automatic do_load(input logic [7:0] data);
        issue(2'b00, data, 4'd0, 1'b0);
        total++;
        if ({bus.S1, bus.S0, bus.D, bus.busy, bus.done, bus.cmd_ready} !== {2'b11, data, 3'b100})
            $display("FAIL load_drive S=%b%b D=%h busy=%b done=%b rdy=%b want S=11 D=%h busy=1 done=0 rdy=0",
                     bus.S1, bus.S0, bus.D, bus.busy, bus.done, bus.cmd_ready, data);
        else passed++;
        @(negedge clk);
        total++;
        if ({q, bus.S1, bus.S0, bus.D, bus.busy, bus.done} !== {data, 2'b00, 8'h00, 2'b11})
            $display("FAIL load_done q=%h S=%b%b D=%h busy=%b done=%b want q=%h S=00 D=00 busy=1 done=1",
                     q, bus.S1, bus.S0, bus.D, bus.busy, bus.done, data);
        else passed++;
        @(negedge clk);
        total++;
        if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b001)
            $display("FAIL load_idle done=%b busy=%b rdy=%b want 0 0 1", bus.done, bus.busy, bus.cmd_ready);
        else passed++;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [3:0] amt, input logic fill, input logic [7:0] want);
        logic [1:0] exp_s;
        logic       exp_sdl, exp_sdr;
        exp_s = (op == 2'b10) ? 2'b10 : 2'b01;
        issue(op, 8'h00, amt, fill);
        for (int i = 0; i < int'(amt); i++) begin
            exp_sdl = (op == 2'b10) ? fill : 1'b0;
            exp_sdr = (op == 2'b10) ? 1'b0 : ((op == 2'b11 && ROT) ? q[0] : fill);
            total++;
            if ({bus.S1, bus.S0, bus.D, bus.done, bus.busy, bus.SDL, bus.SDR} !== {exp_s, 8'h00, 2'b01, exp_sdl, exp_sdr})
                $display("FAIL shift_cyc%0d op=%b S=%b%b D=%h done=%b busy=%b SDL=%b SDR=%b want S=%b D=00 done=0 busy=1 SDL=%b SDR=%b",
                         i, op, bus.S1, bus.S0, bus.D, bus.done, bus.busy, bus.SDL, bus.SDR, exp_s, exp_sdl, exp_sdr);
            else passed++;
            @(negedge clk);
        end
        total++;
        if ({q, bus.S1, bus.S0, bus.done, bus.busy} !== {want, 2'b00, 2'b11})
            $display("FAIL shift_done op=%b amt=%0d q=%h S=%b%b done=%b busy=%b want q=%h S=00 done=1 busy=1",
                     op, amt, q, bus.S1, bus.S0, bus.done, bus.busy, want);
        else passed++;
        @(negedge clk);
        total++;
        if ({q, bus.done, bus.busy, bus.cmd_ready} !== {want, 3'b001})
            $display("FAIL shift_idle q=%h done=%b busy=%b rdy=%b want q=%h 0 0 1", q, bus.done, bus.busy, bus.cmd_ready, want);
        else passed++;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({bus.S1, bus.S0, bus.D, bus.busy, bus.done, bus.cmd_ready} !== 13'd0)
            $display("FAIL reset_outputs S=%b%b D=%h busy=%b done=%b rdy=%b want all 0",
                     bus.S1, bus.S0, bus.D, bus.busy, bus.done, bus.cmd_ready);
        else passed++;
        clr = 1'b0;
        #1;
        total++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", bus.cmd_ready);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_load;
        do_load(8'hA5);
    endtask

    task automatic test_shr;
        run_op(2'b01, 4'd3, 1'b0, 8'h14);
    endtask

    task automatic test_shl;
        run_op(2'b10, 4'd2, 1'b1, 8'h53);
        run_op(2'b10, 4'd0, 1'b1, 8'h53);
    endtask

    task automatic test_ror;
        do_load(8'hA5);
        run_op(2'b11, 4'd4, 1'b0, ROT ? 8'h5A : 8'h0A);
    endtask

    task automatic test_abort;
        do_load(8'hFF);
        issue(2'b01, 8'h00, 4'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        total++;
        if ({bus.S1, bus.S0, bus.D, bus.busy, bus.done, bus.cmd_ready, bus.SDR, q} !== {15'd0, 8'h3F})
            $display("FAIL abort_outputs S=%b%b D=%h busy=%b done=%b rdy=%b SDR=%b q=%h want all 0 q=3f",
                     bus.S1, bus.S0, bus.D, bus.busy, bus.done, bus.cmd_ready, bus.SDR, q);
        else passed++;
        @(negedge clk);
        total++;
        if ({q, bus.done} !== {8'h3F, 1'b0}) $display("FAIL abort_hold q=%h done=%b want q=3f done=0", q, bus.done);
        else passed++;
        clr = 1'b0;
        do_load(8'h3C);
    endtask

    task automatic test_back_to_back;
        do_load(8'h81);
        run_op(2'b10, 4'd10, 1'b1, 8'hFF);
        run_op(2'b01, 4'd15, 1'b0, 8'h00);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        bus.cmd_amt   = 4'd0;
        bus.cmd_fill  = 1'b0;
        test_reset();
        test_load();
        test_shr();
        test_shl();
        test_ror();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
